// File: rtl/tlk2711_irq_pkg.sv
// ============================================================================
// Module      : tlk2711_irq_pkg
// Description : Shared types, codes and record builders for the TLK2711 IRQ
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlk2711_irq_pkg;

    localparam int          REC_W        = 64;
    localparam logic [3:0]  EVT_TX       = 4'd1;
    localparam logic [3:0]  EVT_RX       = 4'd2;
    localparam logic [3:0]  EVT_LOSS     = 4'd3;
    localparam logic [15:0] TX_SIGNATURE = 16'h5AA5;

    localparam logic [REC_W-1:0] TX_RECORD = {EVT_TX, 44'h0, TX_SIGNATURE};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } sched_state_t;

    function automatic logic [REC_W-1:0] rx_record(
        input logic [7:0]  data_type,
        input logic        file_end,
        input logic        checksum,
        input logic [15:0] frame_num,
        input logic [15:0] frame_length
    );
        return {EVT_RX, 18'h0, data_type, file_end, checksum, frame_num, frame_length};
    endfunction

    function automatic logic [REC_W-1:0] loss_record(
        input logic [5:0] rx_status,
        input logic       sync_loss,
        input logic       link_loss
    );
        return {EVT_LOSS, 52'h0, rx_status, sync_loss, link_loss};
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_evt_fifo.sv
// ============================================================================
// Module      : irq_evt_fifo
// Description : Synchronous first-word-fall-through FIFO holding event records.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [6:0]       count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 7'(DEPTH));
    assign empty   = (count == 7'd0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 7'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/tlk2711_irq_sched.sv
// ============================================================================
// Module      : tlk2711_irq_sched
// Description : Captures TX/RX/loss events, queues them in order and presents
//               them to the PS one at a time behind a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlk2711_irq_sched #(
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tx_event,
    input  logic        i_rx_event,
    input  logic        i_loss_event,
    input  logic [7:0]  i_rx_data_type,
    input  logic        i_rx_file_end_flag,
    input  logic        i_rx_checksum_flag,
    input  logic [15:0] i_rx_frame_num,
    input  logic [15:0] i_rx_frame_length,
    input  logic [5:0]  i_rx_status,
    input  logic        i_sync_loss,
    input  logic        i_link_loss,
    input  logic        i_ack,
    input  logic        i_clr_ovf,
    output logic        o_irq,
    output logic [63:0] o_irq_status,
    output logic [6:0]  o_pending,
    output logic        o_overflow,
    output logic [15:0] o_drop_cnt
);

    import tlk2711_irq_pkg::*;

    logic             tx_vld;
    logic             rx_vld;
    logic             loss_vld;
    logic [REC_W-1:0] rx_rec;
    logic [REC_W-1:0] loss_rec;

    logic             sel_tx;
    logic             sel_rx;
    logic             sel_loss;
    logic             arb_push;
    logic [REC_W-1:0] arb_data;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_accept;
    logic [REC_W-1:0] fifo_head;

    logic             tx_load;
    logic             rx_load;
    logic             loss_load;
    logic             tx_drop;
    logic             rx_drop;
    logic             loss_drop;
    logic [1:0]       drop_inc;
    logic [16:0]      drop_sum;

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [7:0]       hold_cnt;
    logic             hold_load;

    // ---------------------------------------------------------------- arbiter
    assign fifo_accept = !fifo_full || fifo_pop;

    always_comb begin
        sel_loss = 1'b0;
        sel_rx   = 1'b0;
        sel_tx   = 1'b0;
        if (fifo_accept) begin
            if (loss_vld) begin
                sel_loss = 1'b1;
            end else if (rx_vld) begin
                sel_rx = 1'b1;
            end else if (tx_vld) begin
                sel_tx = 1'b1;
            end
        end
    end

    assign arb_push = sel_loss || sel_rx || sel_tx;
    assign arb_data = sel_loss ? loss_rec : (sel_rx ? rx_rec : TX_RECORD);

    // ---------------------------------------------------------- capture stage
    // A latch draining this cycle may reload from a coincident pulse.
    assign tx_load   = i_tx_event   && (!tx_vld   || sel_tx);
    assign rx_load   = i_rx_event   && (!rx_vld   || sel_rx);
    assign loss_load = i_loss_event && (!loss_vld || sel_loss);
    assign tx_drop   = i_tx_event   && !tx_load;
    assign rx_drop   = i_rx_event   && !rx_load;
    assign loss_drop = i_loss_event && !loss_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_vld   <= 1'b0;
            rx_vld   <= 1'b0;
            loss_vld <= 1'b0;
            rx_rec   <= '0;
            loss_rec <= '0;
        end else begin
            if (tx_load) begin
                tx_vld <= 1'b1;
            end else if (sel_tx) begin
                tx_vld <= 1'b0;
            end

            if (rx_load) begin
                rx_vld <= 1'b1;
                rx_rec <= rx_record(i_rx_data_type, i_rx_file_end_flag,
                                    i_rx_checksum_flag, i_rx_frame_num,
                                    i_rx_frame_length);
            end else if (sel_rx) begin
                rx_vld <= 1'b0;
            end

            if (loss_load) begin
                loss_vld <= 1'b1;
                loss_rec <= loss_record(i_rx_status, i_sync_loss, i_link_loss);
            end else if (sel_loss) begin
                loss_vld <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ drop count
    assign drop_inc = {1'b0, tx_drop} + {1'b0, rx_drop} + {1'b0, loss_drop};
    assign drop_sum = {1'b0, o_drop_cnt} + {15'd0, drop_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            o_drop_cnt <= 16'd0;
            o_overflow <= 1'b0;
        end else if (i_clr_ovf) begin
            // Clear takes effect first, then this cycle's drops are counted.
            o_drop_cnt <= {14'd0, drop_inc};
            o_overflow <= (drop_inc != 2'd0);
        end else if (drop_inc != 2'd0) begin
            o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            o_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------ FIFO
    irq_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (arb_push),
        .push_data (arb_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_pending)
    );

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (!fifo_empty)      state_nxt = ST_PRESENT;
            ST_PRESENT: if (i_ack)            state_nxt = ST_HOLDOFF;
            ST_HOLDOFF: if (hold_cnt == 8'd0) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_irq     = (state == ST_PRESENT);
        fifo_pop  = (state == ST_IDLE) && !fifo_empty;
        hold_load = (state == ST_PRESENT) && i_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt     <= 8'd0;
            o_irq_status <= '0;
        end else begin
            if (fifo_pop) begin
                o_irq_status <= fifo_head;
            end
            if (hold_load) begin
                hold_cnt <= 8'(HOLDOFF - 1);
            end else if ((state == ST_HOLDOFF) && (hold_cnt != 8'd0)) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlk2711_irq_sched.sv
// ============================================================================
// Module      : tb_tlk2711_irq_sched
// Description : Self-checking bench for tlk2711_irq_sched (vector table plus
//               scoreboard of expected status records).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlk2711_irq_sched;

    localparam int DEPTH   = 8;
    localparam int HOLDOFF = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tx_event, i_rx_event, i_loss_event;
    logic [7:0]  i_rx_data_type;
    logic        i_rx_file_end_flag, i_rx_checksum_flag;
    logic [15:0] i_rx_frame_num, i_rx_frame_length;
    logic [5:0]  i_rx_status;
    logic        i_sync_loss, i_link_loss;
    logic        i_ack, i_clr_ovf;
    logic        o_irq;
    logic [63:0] o_irq_status;
    logic [6:0]  o_pending;
    logic        o_overflow;
    logic [15:0] o_drop_cnt;

    tlk2711_irq_sched #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_tx_event         (i_tx_event),
        .i_rx_event         (i_rx_event),
        .i_loss_event       (i_loss_event),
        .i_rx_data_type     (i_rx_data_type),
        .i_rx_file_end_flag (i_rx_file_end_flag),
        .i_rx_checksum_flag (i_rx_checksum_flag),
        .i_rx_frame_num     (i_rx_frame_num),
        .i_rx_frame_length  (i_rx_frame_length),
        .i_rx_status        (i_rx_status),
        .i_sync_loss        (i_sync_loss),
        .i_link_loss        (i_link_loss),
        .i_ack              (i_ack),
        .i_clr_ovf          (i_clr_ovf),
        .o_irq              (o_irq),
        .o_irq_status       (o_irq_status),
        .o_pending          (o_pending),
        .o_overflow         (o_overflow),
        .o_drop_cnt         (o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          tx, rx, loss;
        logic [7:0]  dt;
        bit          fe, ck;
        logic [15:0] fn, fl;
        logic [5:0]  st;
        bit          sl, ll;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[5];
    logic [63:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [63:0] m_rx(input logic [7:0] dt, input logic fe, ck,
                                         input logic [15:0] fn, fl);
        return {4'd2, 18'h0, dt, fe, ck, fn, fl};
    endfunction

    function automatic logic [63:0] m_loss(input logic [5:0] st, input logic sl, ll);
        return {4'd3, 52'h0, st, sl, ll};
    endfunction

    function automatic logic [63:0] m_tx();
        return {4'd1, 44'h0, 16'h5AA5};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rx(input logic [7:0] dt, input logic fe, ck, input logic [15:0] fn, fl);
        i_rx_data_type = dt; i_rx_file_end_flag = fe; i_rx_checksum_flag = ck;
        i_rx_frame_num = fn; i_rx_frame_length = fl;
    endtask

    task automatic set_loss(input logic [5:0] st, input logic sl, ll);
        i_rx_status = st; i_sync_loss = sl; i_link_loss = ll;
    endtask

    // Drives a one-cycle pulse; kept events are queued in loss, RX, TX order.
    task automatic fire(input bit tx, rx, loss, input bit kept);
        i_tx_event = tx; i_rx_event = rx; i_loss_event = loss;
        if (kept) begin
            if (loss) sb.push_back(m_loss(i_rx_status, i_sync_loss, i_link_loss));
            if (rx)   sb.push_back(m_rx(i_rx_data_type, i_rx_file_end_flag, i_rx_checksum_flag,
                                        i_rx_frame_num, i_rx_frame_length));
            if (tx)   sb.push_back(m_tx());
        end
        tick();
        i_tx_event = 1'b0; i_rx_event = 1'b0; i_loss_event = 1'b0;
    endtask

    task automatic wait_irq();
        int n = 0;
        while (o_irq !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (o_irq !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL irq_timeout: o_irq=%b expected 1", o_irq);
        end
    endtask

    task automatic expect_present(input string name);
        wait_irq();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: status %h presented, expected none", name, o_irq_status);
        end else begin
            check64(name, o_irq_status, sb.pop_front());
        end
    endtask

    task automatic do_ack();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
    endtask

    task automatic drain(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            expect_present(name);
            do_ack();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check64({tag, "_irq"},      64'(o_irq),        64'd0);
        check64({tag, "_status"},   o_irq_status,      64'd0);
        check64({tag, "_pending"},  64'(o_pending),    64'd0);
        check64({tag, "_overflow"}, 64'(o_overflow),   64'd0);
        check64({tag, "_drop_cnt"}, 64'(o_drop_cnt),   64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 16'h0003, 16'h0366, 6'h00, 1'b0, 1'b0,
                    64'h2000_0007_0003_0366};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'h00, 1'b0, 1'b0,
                    64'h1000_0000_0000_5AA5};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'h2A, 1'b1, 1'b0,
                    64'h3000_0000_0000_00AA};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 16'hABCD, 16'h1234, 6'h00, 1'b0, 1'b0,
                    64'h2000_030D_ABCD_1234};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'h3F, 1'b0, 1'b1,
                    64'h3000_0000_0000_00FD};

        rst = 1'b1;
        i_tx_event = 1'b0; i_rx_event = 1'b0; i_loss_event = 1'b0;
        i_ack = 1'b0; i_clr_ovf = 1'b0;
        set_rx(8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_loss(6'h00, 1'b0, 1'b0);
        tick(3);
        rst = 1'b0;
        tick();
        check_all_zero("reset");

        // Single RX event: latency to o_irq is exactly three cycles.
        set_rx(vecs[0].dt, vecs[0].fe, vecs[0].ck, vecs[0].fn, vecs[0].fl);
        fire(1'b0, 1'b1, 1'b0, 1'b1);
        check64("lat_c1_irq", 64'(o_irq), 64'd0);
        tick();
        check64("lat_c2_irq", 64'(o_irq), 64'd0);
        tick();
        check64("lat_c3_irq", 64'(o_irq), 64'd1);
        check64("lat_c3_status", o_irq_status, vecs[0].exp);
        expect_present("lat_sb");
        do_ack();
        check64("ack_irq_low", 64'(o_irq), 64'd0);
        check64("ack_status_held", o_irq_status, vecs[0].exp);
        tick(HOLDOFF + 2);

        // Vector table: one event each, record format per source.
        for (int i = 0; i < 5; i++) begin
            set_rx(vecs[i].dt, vecs[i].fe, vecs[i].ck, vecs[i].fn, vecs[i].fl);
            set_loss(vecs[i].st, vecs[i].sl, vecs[i].ll);
            fire(vecs[i].tx, vecs[i].rx, vecs[i].loss, 1'b1);
            wait_irq();
            check64($sformatf("vec%0d_table", i), o_irq_status, vecs[i].exp);
            expect_present($sformatf("vec%0d_sb", i));
            do_ack();
            tick(HOLDOFF + 2);
        end

        // All three sources in one cycle.
        set_rx(8'h5A, 1'b1, 1'b0, 16'h0011, 16'h0022);
        set_loss(6'h15, 1'b1, 1'b1);
        fire(1'b1, 1'b1, 1'b1, 1'b1);
        drain("simul", 3);
        check64("simul_drop_cnt", 64'(o_drop_cnt), 64'd0);
        check64("simul_overflow", 64'(o_overflow), 64'd0);
        tick(HOLDOFF + 4);

        // Holdoff timing with stray acks in HOLDOFF and IDLE.
        set_rx(8'h77, 1'b0, 1'b0, 16'h0100, 16'h0200);
        fire(1'b1, 1'b1, 1'b0, 1'b1);
        expect_present("hold_first");
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        lows = 0;
        for (int k = 1; k <= HOLDOFF + 1; k++) begin
            if (o_irq === 1'b0) lows++;
            if (k == 5) begin
                check64("hold_pending_before", 64'(o_pending), 64'd1);
                i_ack = 1'b1;
            end
            if (k == 6) begin
                i_ack = 1'b0;
                check64("hold_pending_after", 64'(o_pending), 64'd1);
            end
            if (k == HOLDOFF + 1) i_ack = 1'b1;
            tick();
        end
        i_ack = 1'b0;
        check64("hold_low_cycles", 64'(lows), 64'(HOLDOFF + 1));
        check64("hold_irq_at_a18", 64'(o_irq), 64'd1);
        expect_present("hold_second");
        tick();
        check64("hold_idle_ack_ignored", 64'(o_irq), 64'd1);
        do_ack();
        tick(HOLDOFF + 4);

        // Ack in IDLE with nothing queued.
        do_ack();
        check64("idle_ack_irq", 64'(o_irq), 64'd0);
        check64("idle_ack_pending", 64'(o_pending), 64'd0);

        // Overflow: 12 TX pulses, no acks.
        for (int i = 0; i < 12; i++) begin
            fire(1'b1, 1'b0, 1'b0, (i < 10));
            tick();
        end
        tick(2);
        check64("ovf_irq", 64'(o_irq), 64'd1);
        check64("ovf_pending", 64'(o_pending), 64'd8);
        check64("ovf_overflow", 64'(o_overflow), 64'd1);
        check64("ovf_drop_cnt", 64'(o_drop_cnt), 64'd2);
        drain("ovf_drain", 10);
        tick(HOLDOFF + 4);
        check64("ovf_drained_pending", 64'(o_pending), 64'd0);
        check64("ovf_drained_irq", 64'(o_irq), 64'd0);

        // Clear coinciding with a drop: RX latch is held while loss drains.
        set_rx(8'h21, 1'b1, 1'b1, 16'h0aaa, 16'h0bbb);
        set_loss(6'h01, 1'b0, 1'b1);
        fire(1'b0, 1'b1, 1'b1, 1'b1);
        set_rx(8'hEE, 1'b0, 1'b0, 16'hffff, 16'hffff);
        i_clr_ovf = 1'b1;
        fire(1'b0, 1'b1, 1'b0, 1'b0);
        i_clr_ovf = 1'b0;
        check64("clrdrop_cnt", 64'(o_drop_cnt), 64'd1);
        check64("clrdrop_overflow", 64'(o_overflow), 64'd1);
        drain("clrdrop_drain", 2);
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        check64("clr_cnt", 64'(o_drop_cnt), 64'd0);
        check64("clr_overflow", 64'(o_overflow), 64'd0);
        tick(HOLDOFF + 4);

        // Two drops in one cycle; reloaded loss latch is queued second.
        set_rx(8'h31, 1'b0, 1'b1, 16'h1111, 16'h2222);
        set_loss(6'h0C, 1'b1, 1'b0);
        sb.push_back(m_loss(6'h0C, 1'b1, 1'b0));
        sb.push_back(m_loss(6'h33, 1'b0, 1'b1));
        sb.push_back(m_rx(8'h31, 1'b0, 1'b1, 16'h1111, 16'h2222));
        sb.push_back(m_tx());
        fire(1'b1, 1'b1, 1'b1, 1'b0);
        set_loss(6'h33, 1'b0, 1'b1);
        set_rx(8'h99, 1'b1, 1'b1, 16'h9999, 16'h9999);
        fire(1'b1, 1'b1, 1'b1, 1'b0);
        check64("multidrop_cnt", 64'(o_drop_cnt), 64'd2);
        drain("multidrop_drain", 4);
        tick(HOLDOFF + 4);

        // Reset while presenting with three events queued.
        set_loss(6'h02, 1'b0, 1'b0);
        fire(1'b1, 1'b1, 1'b1, 1'b1);
        tick(3);
        fire(1'b1, 1'b0, 1'b0, 1'b1);
        tick(3);
        check64("prerst_irq", 64'(o_irq), 64'd1);
        check64("prerst_pending", 64'(o_pending), 64'd3);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        sb.delete();
        tick(2);
        check_all_zero("postrst_quiet");

        set_rx(vecs[3].dt, vecs[3].fe, vecs[3].ck, vecs[3].fn, vecs[3].fl);
        fire(1'b0, 1'b1, 1'b0, 1'b1);
        tick(2);
        check64("postrst_irq_c3", 64'(o_irq), 64'd1);
        expect_present("postrst_sb");
        do_ack();
        tick(HOLDOFF + 4);
        check64("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
